fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0, the word address fetched first after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port redirect_valid, input, 1, a taken branch or branch-link target is presented.
REQ-005 SHALL have port redirect_pc, input, 32, the target word address, produced by next-PC logic.
REQ-006 SHALL have port imem_req_valid, output, 1, the fetch request is valid.
REQ-007 SHALL have port imem_req_ready, input, 1, the instruction memory accepts the request.
REQ-008 SHALL have port imem_addr, output, 32, the word address of the request; equals pc.
REQ-009 SHALL have port imem_rsp_valid, input, 1, the response word is valid, at most one per accepted request.
REQ-010 SHALL have port imem_rsp_data, input, 32, the instruction word.
REQ-011 SHALL have port inst_valid, output, 1, an instruction is presented to decode.
REQ-012 SHALL have port inst_ready, input, 1, decode consumes the instruction.
REQ-013 SHALL have port inst_data, output, 32, the held instruction.
REQ-014 SHALL have port inst_pc, output, 32, the word address of inst_data; decode adds 1 to it for the link value.
REQ-015 SHALL have port fetch_pc, output, 32, the current pc register, fed back to next-PC logic.
REQ-016 SHALL have port fetch_count, output, 32, the count of instructions consumed (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT and HOLD, plus a 1-bit squash flag.
REQ-018 IDLE SHALL go to REQ unconditionally on the next edge, with all handshake outputs low.
REQ-019 In REQ, imem_req_valid SHALL equal !redirect_valid; on valid && imem_req_ready the FSM SHALL go to WAIT.
REQ-020 In WAIT, on imem_rsp_valid with squash clear, the block SHALL capture inst_data <= rsp, set inst_pc <= pc and pc <= pc + 1 (mod 2^32, wrapping 0xFFFFFFFF to 0), and go to HOLD.
REQ-021 In HOLD, inst_valid SHALL be 1; on inst_ready the FSM SHALL go to REQ.
REQ-022 inst_valid SHALL be asserted only in HOLD, and inst_data and inst_pc SHALL hold stable while inst_valid && !inst_ready.
REQ-023 Latency: from the cycle a request is accepted to inst_valid SHALL be 1 cycle plus the memory latency (2 cycles minimum); sustained throughput SHALL be one instruction per 3 cycles.
REQ-024 Redirect in REQ SHALL load pc <= redirect_pc and keep the FSM in REQ, with no request issued that cycle.
REQ-025 Redirect in WAIT without imem_rsp_valid SHALL load pc <= redirect_pc and set squash; the next response SHALL be discarded, squash cleared, and the FSM SHALL go to REQ.
REQ-026 Redirect in WAIT in the same cycle as imem_rsp_valid SHALL discard that response, load pc <= redirect_pc, and go to REQ.
REQ-027 Redirect in HOLD SHALL load pc <= redirect_pc, go to REQ and deassert inst_valid next cycle; if inst_ready is also high, the instruction counts as consumed.
REQ-028 Redirect in IDLE SHALL load pc <= redirect_pc.

Reset
REQ-029 While reset_n is low, the block SHALL set state=IDLE, pc=RESET_PC, inst_pc=RESET_PC, inst_data=0, squash=0 and fetch_count=0.
REQ-030 While reset_n is low, imem_req_valid and inst_valid SHALL be 0.
REQ-031 Reset asserted mid-transaction SHALL abandon the transaction, and the first response after release SHALL NOT be expected.

Configuration
REQ-032 With macro FETCH_PERF_CNT_EN defined, fetch_count SHALL increment (wrapping) on each inst_valid && inst_ready.
REQ-033 Without FETCH_PERF_CNT_EN, fetch_count SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-034 Release reset, memory ready always with 1-cycle response -> addresses 0,1,2 requested; inst_pc 0,1,2 with matching data; one instruction per 3 cycles.
REQ-035 Hold inst_ready=0 for 5 cycles in HOLD (inst_pc=4) -> inst_valid, inst_data and inst_pc stable, no new request; then inst_ready=1 -> next request addr=5.
REQ-036 Assert redirect_pc=0x100 in WAIT, response arriving 2 cycles later -> response discarded, inst_valid stays 0, next request addr=0x100.
REQ-037 Assert redirect_pc=0x40 in the same cycle as imem_rsp_valid -> no inst_valid; next imem_addr=0x40.
REQ-038 pc=0xFFFFFFFF fetched -> inst_pc=0xFFFFFFFF, next request addr=0.
REQ-039 With FETCH_PERF_CNT_EN, consume 3 instructions, then pulse reset_n low mid-WAIT -> fetch_count 3 then 0, and the first request after release has addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request, wait for the word, hold it for decode.
// Define FETCH_PERF_CNT_EN to add a counter of instructions consumed by decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] inst_data_q, inst_data_d;
    logic        squash_q, squash_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            inst_pc_q   <= RESET_PC;
            inst_data_q <= 32'd0;
            squash_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_pc_q   <= inst_pc_d;
            inst_data_q <= inst_data_d;
            squash_q    <= squash_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        inst_pc_d      = inst_pc_q;
        inst_data_d    = inst_data_q;
        squash_d       = squash_q;
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_valid) pc_d = redirect_pc;
            end
            REQ: begin
                imem_req_valid = !redirect_valid;
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end else if (imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (imem_rsp_valid) begin
                    squash_d = 1'b0;
                    if (redirect_valid || squash_q) begin
                        state_d = REQ;
                    end else begin
                        inst_data_d = imem_rsp_data;
                        inst_pc_d   = pc_q;
                        pc_d        = pc_q + 32'd1;
                        state_d     = HOLD;
                    end
                end else if (redirect_valid) begin
                    // The in-flight word belongs to the old path; drop it when it lands.
                    squash_d = 1'b1;
                end
            end
            HOLD: begin
                inst_valid = 1'b1;
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = REQ;
                end else if (inst_ready) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_addr = pc_q;
    assign fetch_pc  = pc_q;
    assign inst_data = inst_data_q;
    assign inst_pc   = inst_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 32'd0;
        end else if (inst_valid && inst_ready) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small behavioural instruction memory of configurable latency.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_count;

    int errors = 0;
    int checks = 0;

    // memory model state
    int          lat;
    logic        busy;
    int          cnt;
    logic [31:0] paddr;

    fetch_unit dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fetch_pc       (fetch_pc),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] consumed);
`ifdef FETCH_PERF_CNT_EN
        chk(tag, fetch_count, consumed);
`else
        chk(tag, fetch_count, 32'd0);
`endif
    endtask

    // One clock: sample the request handshake, then advance the memory model after the edge.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        @(negedge clk);
        acc = imem_req_valid && imem_req_ready;
        a   = imem_addr;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (busy) begin
            if (cnt <= 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(paddr);
                busy           = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (acc) begin
            if (lat <= 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(a);
            end else begin
                busy  = 1'b1;
                cnt   = lat - 1;
                paddr = a;
            end
        end
    endtask

    // Starts in REQ with pc=p, ends in HOLD presenting the word fetched from p.
    task automatic fetch_one(input logic [31:0] p);
        chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("req_addr", imem_addr, p);
        tick();
        chk("wait_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
        tick();
        chk("hold_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("hold_inst_pc", inst_pc, p);
        chk("hold_inst_data", inst_data, mem_word(p));
    endtask

    task automatic mem_clear();
        busy           = 1'b0;
        cnt            = 0;
        imem_rsp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        inst_ready     = 1'b1;
        lat            = 1;
        busy           = 1'b0;
        cnt            = 0;
        paddr          = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_fetch_pc", fetch_pc, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_count", fetch_count, 32'd0);

        // sequential fetch, one instruction every 3 cycles
        reset_n = 1'b1;
        tick();
        fetch_one(32'd0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            fetch_one(i);
        end

        // decode stall in HOLD with inst_pc=4
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_inst_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_inst_pc", inst_pc, 32'd4);
            chk("stall_inst_data", inst_data, mem_word(32'd4));
            chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
        end
        inst_ready = 1'b1;
        tick();
        chk("after_stall_req", {31'd0, imem_req_valid}, 32'd1);
        chk("after_stall_addr", imem_addr, 32'd5);
        chk_cnt("count_5", 32'd5);

        // redirect in WAIT before a slow response arrives
        lat = 3;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        chk("squash_fetch_pc", fetch_pc, 32'h100);
        chk("squash_wait_req", {31'd0, imem_req_valid}, 32'd0);
        tick();
        chk("squash_inst_valid_a", {31'd0, inst_valid}, 32'd0);
        chk("squash_still_wait", {31'd0, imem_req_valid}, 32'd0);
        tick();
        chk("squash_inst_valid_b", {31'd0, inst_valid}, 32'd0);
        chk("squash_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("squash_req_addr", imem_addr, 32'h100);
        lat = 1;
        fetch_one(32'h100);
        tick();
        chk_cnt("count_6", 32'd6);

        // redirect coinciding with the response
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("same_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("same_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("same_req_addr", imem_addr, 32'h40);

        // redirect in REQ suppresses the request, then wrap at the top of memory
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        #1;
        chk("redir_req_suppressed", {31'd0, imem_req_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("redir_req_pc", fetch_pc, 32'hFFFF_FFFF);
        fetch_one(32'hFFFF_FFFF);
        chk("wrap_fetch_pc", fetch_pc, 32'd0);
        tick();
        chk("wrap_req_addr", imem_addr, 32'd0);
        chk_cnt("count_7", 32'd7);

        // redirect in HOLD together with inst_ready: consumed
        fetch_one(32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("hold_redir_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("hold_redir_addr", imem_addr, 32'h200);
        chk_cnt("count_8", 32'd8);

        // redirect in HOLD without inst_ready: not consumed
        fetch_one(32'h200);
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        #1;
        chk("hold_redir2_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("hold_redir2_addr", imem_addr, 32'h300);
        chk_cnt("count_8b", 32'd8);

        // fresh start, consume three, then reset in the middle of WAIT
        reset_n = 1'b0;
        mem_clear();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        chk_cnt("count_fresh", 32'd0);
        fetch_one(32'd0);
        tick();
        fetch_one(32'd1);
        tick();
        fetch_one(32'd2);
        tick();
        lat = 3;
        tick();
        chk_cnt("count_3", 32'd3);
        #2;
        reset_n = 1'b0;
        mem_clear();
        #1;
        chk("async_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("async_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("async_rst_fetch_pc", fetch_pc, 32'd0);
        chk("async_rst_count", fetch_count, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        lat     = 1;
        tick();
        fetch_one(32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
